// File: rtl/exu_mdu_ctrl.sv
// RV64M multiply/divide sequencer: 64-step shift-add multiply / restoring divide beside the EXU ALU.
// Latency: result valid 66 edges after accept (1 edge for divide-by-zero / signed overflow).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush kills the op.
module exu_mdu_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic            w_type,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_o,
    output logic            busy
);
    localparam int HALF = XLEN / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_f3;
    logic             op_w, neg_a, neg_b;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  acc_hi, acc_lo, opb;

    function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v, input logic w);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Operand decode at acceptance: extension, magnitudes, special-case detection
    logic            is_div, sgn_a, sgn_b, neg_a_in, neg_b_in, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, sp_raw;

    always_comb begin
        is_div  = func3[2];
        sgn_a   = is_div ? ~func3[0] : (func3 == 3'b001 || func3 == 3'b010);
        sgn_b   = is_div ? ~func3[0] : (func3 == 3'b001);
        a_ext   = rs1;
        b_ext   = rs2;
        min_val = {1'b1, {(XLEN-1){1'b0}}};
        if (w_type) begin
            a_ext   = {{HALF{sgn_a & rs1[HALF-1]}}, rs1[HALF-1:0]};
            b_ext   = {{HALF{sgn_b & rs2[HALF-1]}}, rs2[HALF-1:0]};
            min_val = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end
        neg_a_in = sgn_a & a_ext[XLEN-1];
        neg_b_in = sgn_b & b_ext[XLEN-1];
        mag_a    = neg_a_in ? -a_ext : a_ext;
        mag_b    = neg_b_in ? -b_ext : b_ext;
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && sgn_a && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || div_ovf;
        if (div_zero) sp_raw = func3[1] ? a_ext : '1;
        else          sp_raw = func3[1] ? '0 : a_ext;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rd_addr_o = rd_q;
    assign accept    = in_valid && in_ready && !flush;

    // One iteration: acc_lo holds multiplier (mul) or dividend/quotient (div); acc_hi the partial
    logic [XLEN:0]   mul_sum, div_part;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_part = {acc_hi, acc_lo[XLEN-1]};
        div_ge   = (div_part >= {1'b0, opb});
        div_diff = div_part[XLEN-1:0] - opb;
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_raw;

    always_comb begin
        prod_s  = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_s   = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_s   = neg_a ? -acc_hi : acc_hi;
        if (op_f3[2])             fix_raw = op_f3[1] ? rem_s : quo_s;
        else if (op_f3 == 3'b000) fix_raw = prod_s[XLEN-1:0];
        else                      fix_raw = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == LAST) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (out_valid && out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    // out_valid is registered off DONE, so it rises one edge after DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            rd_q      <= '0;
            op_f3     <= '0;
            op_w      <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
        end else begin
            state     <= state_n;
            out_valid <= (state == S_DONE) && !(out_valid && out_ready) && !flush;
            if (accept) begin
                op_f3  <= func3;
                op_w   <= w_type;
                rd_q   <= rd_addr;
                neg_a  <= neg_a_in;
                neg_b  <= neg_b_in;
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= mag_a;
                opb    <= mag_b;
                if (special) result <= wsext(sp_raw, w_type);
            end else if (state == S_CALC) begin
                cnt <= cnt + 1'b1;
                if (op_f3[2]) begin
                    acc_hi <= div_ge ? div_diff : div_part[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end else if (state == S_FIX) begin
                result <= wsext(fix_raw, op_w);
            end
        end
    end
endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// Bench for exu_mdu_ctrl: directed vector table, hand-written corner sequences, random ops vs model.
module tb_exu_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, w_type, out_valid, out_ready, busy;
    logic [2:0]  func3;
    logic [63:0] rs1, rs2, result;
    logic [4:0]  rd_addr, rd_addr_o;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    exu_mdu_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .func3(func3), .w_type(w_type), .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rd_addr_o(rd_addr_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with plain wide arithmetic
    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [63:0]  r;
        logic [31:0]  x, y, z;
        longint       sa, sb, sq;
        int           sx, sy, sz;
        r = '0;
        if (!f3[2]) begin
            pa = (f3 == 3'b001 || f3 == 3'b010) ? {{64{a[63]}}, a} : {64'b0, a};
            pb = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'b0, b};
            p  = pa * pb;
            if (w)                 r = {{32{p[31]}}, p[31:0]};
            else if (f3 == 3'b000) r = p[63:0];
            else                   r = p[127:64];
        end else if (!w) begin
            sa = a;
            sb = b;
            case (f3[1:0])
                2'b00: if (b == 0) r = ONES; else if (a == MIN && b == ONES) r = a;
                       else begin sq = sa / sb; r = sq; end
                2'b01: if (b == 0) r = ONES; else r = a / b;
                2'b10: if (b == 0) r = a; else if (a == MIN && b == ONES) r = '0;
                       else begin sq = sa % sb; r = sq; end
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end else begin
            x  = a[31:0];
            y  = b[31:0];
            sx = x;
            sy = y;
            case (f3[1:0])
                2'b00: if (y == 0) z = '1; else if (x == 32'h8000_0000 && y == '1) z = x;
                       else begin sz = sx / sy; z = sz; end
                2'b01: if (y == 0) z = '1; else z = x / y;
                2'b10: if (y == 0) z = x; else if (x == 32'h8000_0000 && y == '1) z = '0;
                       else begin sz = sx % sy; z = sz; end
                default: if (y == 0) z = x; else z = x % y;
            endcase
            r = {{32{z[31]}}, z};
        end
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        bit bz, ovf;
        bz  = w ? (b[31:0] == 0) : (b == 0);
        ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN && b == ONES);
        return f3[2] && (bz || (!f3[0] && ovf));
    endfunction

    task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        func3 = f3; w_type = w; rs1 = a; rs2 = b; rd_addr = rd; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        func3 = 3'($urandom); w_type = 1'($urandom); rd_addr = 5'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat, input int stall);
        logic [4:0] rd;
        int lat;
        rd = 5'($urandom);
        start_op(f3, w, a, b, rd);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result, exp);
        check({name, " rd_addr_o"}, 64'(rd_addr_o), 64'(rd));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({name, " stall out_valid"}, 64'(out_valid), 64'd1);
            check({name, " stall result"}, result, exp);
            check({name, " stall rd"}, 64'(rd_addr_o), 64'(rd));
            check({name, " stall in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " drop out_valid"}, 64'(out_valid), 64'd0);
        check({name, " in_ready after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b;
        int          mode;
        bit          seen;

        tbl[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
        tbl[1]  = '{3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        tbl[2]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        tbl[3]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        tbl[4]  = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66};
        tbl[5]  = '{3'b101, 1'b0, 64'd5, 64'd0, ONES, 1};
        tbl[6]  = '{3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        tbl[7]  = '{3'b100, 1'b0, MIN, ONES, MIN, 1};
        tbl[8]  = '{3'b110, 1'b0, MIN, ONES, 64'd0, 1};
        tbl[9]  = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1};
        tbl[10] = '{3'b001, 1'b0, ONES, ONES, 64'd0, 66};
        tbl[11] = '{3'b010, 1'b0, ONES, 64'd2, ONES, 66};
        tbl[12] = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 66};
        tbl[13] = '{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
        tbl[14] = '{3'b000, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 66};
        tbl[15] = '{3'b101, 1'b0, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        func3 = '0; w_type = 1'b0; rs1 = '0; rs2 = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", result, 64'd0);
        check("reset rd_addr_o", 64'(rd_addr_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].b,
                   tbl[i].exp, tbl[i].lat, 0);

        // mulw with consumer stalled for 5 cycles
        run_op("mulw_stall", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 5);

        // flush on cycle 10 of CALC
        start_op(3'b000, 1'b0, 64'd3, 64'd5, 5'd9);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no out_valid", 64'(seen), 64'd0);

        // flush together with in_valid in IDLE
        @(negedge clk);
        func3 = 3'b000; w_type = 1'b0; rs1 = 64'd2; rs2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush+in_valid busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("flush+in_valid still idle", 64'(in_ready), 64'd1);

        // reset mid-CALC
        start_op(3'b100, 1'b0, 64'd1000, 64'd7, 5'd21);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst mid in_ready", 64'(in_ready), 64'd1);
        check("rst mid out_valid", 64'(out_valid), 64'd0);
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid result", result, 64'd0);
        check("rst mid rd_addr_o", 64'(rd_addr_o), 64'd0);
        run_op("after rst", 3'b100, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 0);

        // random ops against the model
        for (int k = 0; k < 40; k++) begin
            f3   = 3'($urandom_range(0, 7));
            w    = (f3 == 3'b000 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            mode = $urandom_range(0, 9);
            if (mode == 0) b = w ? {$urandom, 32'h0} : 64'd0;
            if (mode == 1) begin
                a = w ? {$urandom, 32'h8000_0000} : MIN;
                b = w ? {$urandom, 32'hFFFF_FFFF} : ONES;
            end
            if (mode == 2) b = 64'($urandom_range(1, 1000));
            if (mode == 3) a = 64'($urandom_range(0, 1000));
            run_op($sformatf("rnd%0d f3=%0d w=%0d", k, f3, w), f3, w, a, b,
                   model(f3, w, a, b), is_special(f3, w, a, b) ? 1 : 66, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
